// File: rtl/console_renderer.sv
`default_nettype none
// ============================================================================
// console_renderer : text-mode pixel pipeline (font fetch, palette, blink, cursor)
// Revision 1.0 - initial release
// ============================================================================
module console_renderer #(
  parameter int BIT_WIDTH    = 12,
  parameter int BIT_HEIGHT   = 11,
  parameter int FONT_WIDTH   = 8,
  parameter int FONT_HEIGHT  = 16,
  parameter int BLINK_FRAMES = 32,
  parameter int CURSOR_START = 14,
  parameter int CURSOR_END   = 15
) (
  input  logic                                          clk_pixel,
  input  logic                                          reset,
  input  logic [BIT_WIDTH-1:0]                          cx,
  input  logic [BIT_HEIGHT-1:0]                         cy,
  input  logic                                          in_active,
  input  logic [7:0]                                    codepoint,
  input  logic [7:0]                                    charattr,
  input  logic                                          cursor_en,
  input  logic [BIT_WIDTH-$clog2(FONT_WIDTH)-1:0]       cursor_col,
  input  logic [BIT_HEIGHT-$clog2(FONT_HEIGHT)-1:0]     cursor_row,
  output logic [8+$clog2(FONT_HEIGHT)-1:0]              font_addr,
  input  logic [FONT_WIDTH-1:0]                         font_row,
  output logic [23:0]                                   rgb,
  output logic                                          rgb_valid
);
  localparam int HW    = $clog2(FONT_WIDTH);
  localparam int VW    = $clog2(FONT_HEIGHT);
  localparam int COL_W = BIT_WIDTH - HW;
  localparam int ROW_W = BIT_HEIGHT - VW;
  localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

  function automatic logic [FONT_HEIGHT-1:0] cursor_rows();
    logic [FONT_HEIGHT-1:0] m;
    m = '0;
    for (int i = 0; i < FONT_HEIGHT; i++)
      if (i >= CURSOR_START && i <= CURSOR_END) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [FONT_HEIGHT-1:0] CURSOR_ROWS = cursor_rows();

  function automatic logic [23:0] palette(input logic [3:0] idx);
    logic [7:0] on, off;
    on  = idx[3] ? 8'hFF : 8'hAA;
    off = idx[3] ? 8'h55 : 8'h00;
    if (idx == 4'd6) palette = 24'hAA5500;
    else             palette = {idx[2] ? on : off, idx[1] ? on : off, idx[0] ? on : off};
  endfunction

  // Position counters and blink state
  logic [HW-1:0]         h_q, h_d, hidx_c;
  logic [COL_W-1:0]      col_q, col_d, col_c;
  logic [VW-1:0]         v_q, v_d, vidx_c;
  logic [ROW_W-1:0]      row_q, row_d, row_c;
  logic [BIT_HEIGHT-1:0] prev_cy_q, prev_cy_d;
  logic [CNT_W-1:0]      frame_q, frame_d;
  logic                  phase_q, phase_d, started_q, started_d;
  logic                  frame_start_c;

  // Stage 1 / stage 2 context and stage 3 outputs
  logic [8+VW-1:0] font_addr_q, font_addr_d;
  logic [HW-1:0]   s1_hidx_q, s1_hidx_d, s2_hidx_q;
  logic [23:0]     s1_fg_q, s1_fg_d, s1_bg_q, s1_bg_d, s2_fg_q, s2_bg_q;
  logic            s1_blink_q, s1_blink_d, s2_blink_q;
  logic            s1_active_q, s1_active_d, s2_active_q;
  logic            s1_hit_q, s1_hit_d, s2_hit_q;
  logic            s1_phase_q, s1_phase_d, s2_phase_q;
  logic [23:0]     rgb_q, rgb_d;
  logic            rgb_valid_q, rgb_valid_d;

  always_comb begin
    hidx_c = h_q;
    col_c  = col_q;
    if (cx == '0) begin
      hidx_c = '0;
      col_c  = '0;
    end
    {col_d, h_d} = {col_c, hidx_c} + BIT_WIDTH'(1);

    vidx_c = v_q;
    row_c  = row_q;
    frame_start_c = (cx == '0) && (cy == '0);
    if (frame_start_c) begin
      vidx_c = '0;
      row_c  = '0;
    end else if (cy != prev_cy_q) begin
      vidx_c = v_q + VW'(1);
      if (&v_q) row_c = row_q + ROW_W'(1);
    end
    v_d       = vidx_c;
    row_d     = row_c;
    prev_cy_d = cy;

    // The frame start that opens frame 0 closes no frame, so it is not counted.
    frame_d   = frame_q;
    phase_d   = phase_q;
    started_d = started_q;
    if (frame_start_c) begin
      if (!started_q) begin
        started_d = 1'b1;
      end else if (frame_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + CNT_W'(1);
      end
    end

    font_addr_d = {codepoint, vidx_c};
    s1_hidx_d   = hidx_c;
    s1_fg_d     = palette(charattr[3:0]);
    s1_bg_d     = palette({1'b0, charattr[6:4]});
    s1_blink_d  = charattr[7];
    s1_active_d = in_active;
    s1_phase_d  = phase_d;
    s1_hit_d    = cursor_en && (col_c == cursor_col) && (row_c == cursor_row)
                  && CURSOR_ROWS[vidx_c];

    rgb_d       = '0;
    rgb_valid_d = 1'b0;
    if (s2_active_q) begin
      rgb_valid_d = 1'b1;
      if (s2_hit_q && !s2_phase_q)      rgb_d = s2_fg_q;
      else if (s2_blink_q && s2_phase_q) rgb_d = s2_bg_q;
      else                               rgb_d = font_row[~s2_hidx_q] ? s2_fg_q : s2_bg_q;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      h_q <= '0; col_q <= '0; v_q <= '0; row_q <= '0; prev_cy_q <= '0;
      frame_q <= '0; phase_q <= 1'b0; started_q <= 1'b0;
      font_addr_q <= '0; s1_hidx_q <= '0; s1_fg_q <= '0; s1_bg_q <= '0;
      s1_blink_q <= 1'b0; s1_active_q <= 1'b0; s1_hit_q <= 1'b0; s1_phase_q <= 1'b0;
      s2_hidx_q <= '0; s2_fg_q <= '0; s2_bg_q <= '0;
      s2_blink_q <= 1'b0; s2_active_q <= 1'b0; s2_hit_q <= 1'b0; s2_phase_q <= 1'b0;
      rgb_q <= '0; rgb_valid_q <= 1'b0;
    end else begin
      h_q <= h_d; col_q <= col_d; v_q <= v_d; row_q <= row_d; prev_cy_q <= prev_cy_d;
      frame_q <= frame_d; phase_q <= phase_d; started_q <= started_d;
      font_addr_q <= font_addr_d; s1_hidx_q <= s1_hidx_d; s1_fg_q <= s1_fg_d;
      s1_bg_q <= s1_bg_d; s1_blink_q <= s1_blink_d; s1_active_q <= s1_active_d;
      s1_hit_q <= s1_hit_d; s1_phase_q <= s1_phase_d;
      s2_hidx_q <= s1_hidx_q; s2_fg_q <= s1_fg_q; s2_bg_q <= s1_bg_q;
      s2_blink_q <= s1_blink_q; s2_active_q <= s1_active_q; s2_hit_q <= s1_hit_q;
      s2_phase_q <= s1_phase_q;
      rgb_q <= rgb_d; rgb_valid_q <= rgb_valid_d;
    end
  end

  assign font_addr = font_addr_q;
  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_console_renderer.sv
`default_nettype none
// ============================================================================
// tb_console_renderer : raster-scan bench with font ROM model and pixel reference
// Revision 1.0 - initial release
// ============================================================================
module tb_console_renderer;
  localparam int BLINK = 2;
  localparam int LINE_W = 32;
  localparam int FRAME_H = 48;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] cx = '0;
  logic [10:0] cy = '0;
  logic        in_active = 1'b0;
  logic [7:0]  codepoint = '0, charattr = '0;
  logic        cursor_en = 1'b0;
  logic [8:0]  cursor_col = '0;
  logic [6:0]  cursor_row = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_row = '0;
  logic [23:0] rgb;
  logic        rgb_valid;

  int n_checks = 0;
  int n_fail = 0;
  int frames_seen = -1;
  logic [23:0] exp_rgb [2];
  logic        exp_v [2];

  typedef struct {
    int x; int y; logic [7:0] cp; logic [7:0] attr; logic act; logic [23:0] rgb; logic v;
  } vec_t;
  vec_t tbl[$];

  console_renderer #(
    .BIT_WIDTH(12), .BIT_HEIGHT(11), .FONT_WIDTH(8), .FONT_HEIGHT(16),
    .BLINK_FRAMES(BLINK), .CURSOR_START(14), .CURSOR_END(15)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy), .in_active(in_active),
    .codepoint(codepoint), .charattr(charattr), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .font_addr(font_addr),
    .font_row(font_row), .rgb(rgb), .rgb_valid(rgb_valid)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [7:0] rom(input logic [7:0] cp, input logic [3:0] v);
    if (cp == 8'h41) return 8'h81;
    if (cp == 8'hDB) return 8'hFF;
    if (cp == 8'h20) return 8'h00;
    return cp ^ {v, ~v};
  endfunction

  always @(posedge clk_pixel) font_row <= rom(font_addr[11:4], font_addr[3:0]);

  // Palette from the colour rules: each set R/G/B bit is 0xAA, intensity adds 0x55.
  function automatic logic [23:0] pal(input int i);
    int c [3];
    if (i == 6) return 24'hAA5500;
    for (int k = 0; k < 3; k++)
      c[k] = (((i >> (2 - k)) & 1) != 0 ? 170 : 0) + (((i >> 3) & 1) != 0 ? 85 : 0);
    return 24'(c[0] * 65536 + c[1] * 256 + c[2]);
  endfunction

  function automatic int find(input int x, input int y);
    foreach (tbl[i]) if (tbl[i].x == x && tbl[i].y == y) return i;
    return -1;
  endfunction

  task automatic add(input int x, input int y, input logic [7:0] cp, input logic [7:0] attr,
                     input logic act, input logic [23:0] e_rgb, input logic e_v);
    vec_t t;
    t.x = x; t.y = y; t.cp = cp; t.attr = attr; t.act = act; t.rgb = e_rgb; t.v = e_v;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cx=%0d cy=%0d frame=%0d): got %h, expected %h",
               name, cx, cy, frames_seen, got, exp);
    end
  endtask

  task automatic clear_pipe();
    exp_rgb[0] = '0; exp_rgb[1] = '0; exp_v[0] = 1'b0; exp_v[1] = 1'b0;
    frames_seen = -1;
  endtask

  task automatic step(input int x, input int y, input logic act,
                      input logic [7:0] cp, input logic [7:0] at, input int gi);
    int vi, hi, col, row;
    logic [7:0] fr;
    logic ph, hit, e_v;
    logic [23:0] e_rgb, fg, bg;
    cx = 12'(x); cy = 11'(y); in_active = act; codepoint = cp; charattr = at;
    if (x == 0 && y == 0) frames_seen++;
    vi = y % 16; hi = x % 8; col = x / 8; row = y / 16;
    fr = rom(cp, 4'(vi));
    ph = ((frames_seen / BLINK) % 2) == 1;
    fg = pal(int'(at[3:0]));
    bg = pal(int'(at[6:4]));
    hit = cursor_en && (col == int'(cursor_col)) && (row == int'(cursor_row))
          && vi >= 14 && vi <= 15;
    e_rgb = '0; e_v = 1'b0;
    if (act) begin
      e_v = 1'b1;
      if (hit && !ph)     e_rgb = fg;
      else if (at[7] && ph) e_rgb = bg;
      else                e_rgb = fr[7 - hi] ? fg : bg;
    end
    if (gi >= 0) begin
      e_rgb = tbl[gi].rgb;
      e_v   = tbl[gi].v;
    end
    @(posedge clk_pixel); #1;
    check("font_addr", 32'(font_addr), 32'({cp, 4'(vi)}));
    check("rgb", 32'(rgb), 32'(exp_rgb[1]));
    check("rgb_valid", 32'(rgb_valid), 32'(exp_v[1]));
    exp_rgb[1] = exp_rgb[0]; exp_v[1] = exp_v[0];
    exp_rgb[0] = e_rgb;      exp_v[0] = e_v;
  endtask

  // mode 0: table frame, mode 1: cursor/blink regions, mode 2: fully random
  task automatic run_frame(input int mode, input int last_line);
    for (int y = 0; y < FRAME_H && y <= last_line; y++) begin
      for (int x = 0; x < LINE_W; x++) begin
        logic [7:0] cp, at;
        logic act;
        int gi;
        cp = 8'($urandom); at = 8'($urandom);
        act = ($urandom_range(0, 7) != 0);
        gi = -1;
        if (x == 0 && y == 0) act = 1'b1;
        if (mode < 2) begin
          if (y >= 29 && y <= 31 && x >= 16 && x <= 23) begin cp = 8'h20; at = 8'h07; act = 1'b1; end
          if (y >= 40) begin cp = 8'hDB; at = 8'h8E; act = 1'b1; end
        end
        if (mode == 0) begin
          gi = find(x, y);
          if (gi >= 0) begin cp = tbl[gi].cp; at = tbl[gi].attr; act = tbl[gi].act; end
        end
        step(x, y, act, cp, at, gi);
      end
    end
  endtask

  logic [23:0] pal_exp [16] = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                                24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                                24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                                24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};

  initial begin
    for (int i = 0; i < 8; i++)
      add(i, 0, 8'h41, 8'h1F, 1'b1, (i == 0 || i == 7) ? 24'hFFFFFF : 24'h0000AA, 1'b1);
    for (int i = 0; i < 16; i++) add(i, 1, 8'hDB, 8'(i), 1'b1, pal_exp[i], 1'b1);
    for (int i = 0; i < 8; i++)  add(i, 2, 8'h20, 8'(i * 16), 1'b1, pal_exp[i], 1'b1);
    add(8, 3, 8'hDB, 8'h0C, 1'b1, 24'hFF5555, 1'b1);
    add(9, 3, 8'hDB, 8'h0C, 1'b0, 24'h000000, 1'b0);
    add(10, 3, 8'hDB, 8'h0C, 1'b1, 24'hFF5555, 1'b1);
    add(16, 14, 8'h20, 8'h07, 1'b1, 24'h000000, 1'b1);
    add(16, 29, 8'h20, 8'h07, 1'b1, 24'h000000, 1'b1);
    add(16, 30, 8'h20, 8'h07, 1'b1, 24'hAAAAAA, 1'b1);
    add(23, 31, 8'h20, 8'h07, 1'b1, 24'hAAAAAA, 1'b1);
    add(0, 40, 8'hDB, 8'h8E, 1'b1, 24'hFFFF55, 1'b1);

    cursor_en = 1'b1; cursor_col = 9'd2; cursor_row = 7'd1;
    cx = '0; cy = '0; in_active = 1'b1; codepoint = 8'h41; charattr = 8'h1F;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("reset rgb", 32'(rgb), 32'h0);
    check("reset rgb_valid", 32'(rgb_valid), 32'h0);
    check("reset font_addr", 32'(font_addr), 32'h0);
    reset = 1'b0;
    clear_pipe();

    run_frame(0, FRAME_H - 1);
    for (int f = 1; f < 6; f++) run_frame(1, FRAME_H - 1);
    for (int f = 0; f < 3; f++) begin
      cursor_en = 1'($urandom); cursor_col = 9'($urandom_range(0, 3));
      cursor_row = 7'($urandom_range(0, 2));
      run_frame(2, FRAME_H - 1);
    end

    cursor_en = 1'b1; cursor_col = 9'd2; cursor_row = 7'd1;
    run_frame(1, 9);
    #2 reset = 1'b1;
    #1;
    check("async reset rgb", 32'(rgb), 32'h0);
    check("async reset rgb_valid", 32'(rgb_valid), 32'h0);
    check("async reset font_addr", 32'(font_addr), 32'h0);
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    clear_pipe();
    for (int f = 0; f < 4; f++) run_frame(1, FRAME_H - 1);
    step(LINE_W, FRAME_H - 1, 1'b0, 8'h00, 8'h00, -1);
    step(LINE_W + 1, FRAME_H - 1, 1'b0, 8'h00, 8'h00, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/console_renderer.md
# console_renderer

Pipelined text-mode pixel renderer that sits between the video timing generator and the TMDS/VGA output stage. For each pixel coordinate it fetches the glyph row for the current character from an external synchronous font ROM, decodes the character attribute through an internal 16-colour palette, and applies a frame-counted attribute blink. It also applies a hardware text cursor, so the text buffer no longer has to emulate one. Font geometry, blink rate and cursor shape are parameters.

## Interface
- BIT_WIDTH, 12, width of cx
- BIT_HEIGHT, 11, width of cy
- FONT_WIDTH, 8, glyph width in pixels (power of two)
- FONT_HEIGHT, 16, glyph height in pixels (power of two)
- BLINK_FRAMES, 32, frames per blink half-period (≥1)
- CURSOR_START, 14, first glyph row drawn as cursor
- CURSOR_END, 15, last glyph row drawn as cursor (≥ CURSOR_START)

Derived widths: HW = clog2(FONT_WIDTH), VW = clog2(FONT_HEIGHT), COL_W = BIT_WIDTH−HW, ROW_W = BIT_HEIGHT−VW.

- clk_pixel  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- cx  in  BIT_WIDTH  pixel x
- cy  in  BIT_HEIGHT  pixel y
- in_active  in  1  cx/cy inside visible area
- codepoint  in  8  character at (cx,cy)
- charattr  in  8  attribute: [7] blink, [6:4] bg index, [3:0] fg index
- cursor_en  in  1  cursor enable
- cursor_col  in  COL_W  cursor character column
- cursor_row  in  ROW_W  cursor character row
- font_addr  out  8+VW  {codepoint, glyph row} to font ROM
- font_row  in  FONT_WIDTH  ROM data, valid one edge after font_addr is sampled; bit FONT_WIDTH−1 = leftmost pixel
- rgb  out  24  pixel colour {R,G,B}
- rgb_valid  out  1  rgb corresponds to an active pixel

## Operation
- Character position: hidx = cx mod FONT_WIDTH, col = cx / FONT_WIDTH, vidx = cy mod FONT_HEIGHT, row = cy / FONT_HEIGHT. Implement these with counters, not dividers: clear h-counters when cx==0 and clear v-counters when cx==0 && cy==0. Advance the v-counters when cy differs from the previous cy. cx increments by 1 per clock within a line; cy increments by 1 per line.
- Stage 1 (edge k): register font_addr = {codepoint, vidx}. Alongside it, register the stage-1 context: hidx, the decoded fg/bg colours, the blink bit, in_active and cursor_hit.
  - cursor_hit = cursor_en && col==cursor_col && row==cursor_row && CURSOR_START ≤ vidx ≤ CURSOR_END.
- ROM (edge k+1): the external ROM samples font_addr. The stage-1 context is copied to stage 2 on the same edge.
- Stage 3 (edge k+2): select the pixel and drive rgb/rgb_valid.
  - If !active: rgb = 0, rgb_valid = 0.
  - Else if cursor_hit && phase==0: rgb = fg.
  - Else if blink && phase==1: rgb = bg.
  - Else: rgb = font_row[FONT_WIDTH−1−hidx] ? fg : bg.
  - In every active case rgb_valid = 1.
- Blink phase:
  - A frame counter (width clog2(BLINK_FRAMES)+1) increments on each cycle where cx==0 && cy==0.
  - When the counter reaches BLINK_FRAMES−1, it returns to 0 and phase toggles on the same edge.
  - The cursor is visible in phase 0. Blinking characters are hidden in phase 1.
- Palette (index i, bits b3..b0 = I,R,G,B): each set colour bit gives component 0xAA, and I adds 0x55 to every component.
  - Exception: index 6 = 0xAA5500.
  - Examples: 0→000000, 1→0000AA, 4→AA0000, 7→AAAAAA, 8→555555, 14→FFFF55, 15→FFFFFF.
  - bg uses index {0, charattr[6:4]}.

## Timing
- Reset values:
  - rgb = 0, rgb_valid = 0, font_addr = 0.
  - All h/v/col/row counters = 0, frame counter = 0, phase = 0.
  - All pipeline context is cleared, so inactive.
- Latency: inputs sampled at edge k appear on rgb/rgb_valid after edge k+2, with a throughput of one pixel per clock and no stalls.
- font_addr changes only on clk_pixel edges. The ROM has exactly one edge of read latency.
- Line start: when cx==0, hidx and col are 0 for that same pixel.
- Frame start when cy ≠ 0: hidx and col restart, but vidx and row do not.
- Glyph row wrap: vidx FONT_HEIGHT−1 → 0 and row increments on the cy change.
- Cursor and blink both apply: in phase 0 the cursor wins (fg); in phase 1 a blinking character shows bg.
- Reset asserted mid-frame clears the pipeline immediately (asynchronously). The first rgb_valid after release comes two edges after the first active sample.
- cursor_col/cursor_row/cursor_en are sampled in stage 1 with the pixel they apply to.

## Test plan
- Reset held, then released at cx=0, cy=0 with in_active=1 → rgb=0 and rgb_valid=0 until edge k+2; rgb_valid=1 afterwards.
- ROM model returns font_row=0x81 for {0x41,vidx}; codepoint=0x41, charattr=0x1F, cx=0..7 → rgb = FFFFFF, 0000AA×6, FFFFFF, each appearing 2 edges after its cx.
- Sweep cy=0..47 with FONT_HEIGHT=16 → font_addr low bits cycle 0..15 three times; row = 0,1,2 at the cursor comparator.
- cursor_en=1, cursor_col=2, cursor_row=1, charattr=0x07, glyph row 0 → pixels x=16..23 at y=30,31 are AAAAAA in phase 0 and 000000 in phase 1; y=29 is 000000 in both phases.
- charattr=0x8E, font_row=0xFF, BLINK_FRAMES=2 → frames 0,1 show FFFF55; frames 2,3 show 000000; frames 4,5 show FFFF55 again.
- in_active=0 for a pixel mid-stream → exactly that pixel has rgb=0 and rgb_valid=0, two edges later; neighbouring pixels are unaffected.
